crc_frame_encoder: RTL and testbench
====================================

# crc_frame_encoder

Upstream stage of the CRC-4/4FSK transmit path. Accepts a 12-bit payload word over a valid/ready handshake and computes its CRC-4 remainder bit-serially with polynomial x^4+x+1. It then presents the 16-bit code word `CRC_code` to the bit serializer, changing the word only on the frame boundary signalled by the symbol timing counters, so the word is stable for all 16 symbols of a frame.

## Interface
- `IDLE_CODE`, default 16'h0000: word loaded at a frame boundary when no encoded payload is pending.
- `clk_sys`  in  1  system clock; all flops on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `phase`  in  8  symbol phase counter from the timing block, 0..255.
- `sign_cnt`  in  4  symbol index within frame from the timing block, 0..15.
- `data_in`  in  12  payload word; sampled on handshake.
- `data_valid`  in  1  payload offered.
- `data_ready`  out  1  encoder can accept a payload; high only in IDLE.
- `CRC_code`  out  16  code word; [15:4] = payload, [3:0] = CRC remainder; bit n is transmitted in symbol n.
- `code_valid`  out  1  high for the whole frame in which `CRC_code` carries a real payload; low for IDLE_CODE frames.

## Operation
- Frame boundary `fb` = (sign_cnt==15 && phase==255): the last clk_sys cycle of a frame. Outputs update on the edge ending that cycle, which is the same edge on which the timing counters wrap to 0/0.
- FSM states are IDLE, CALC and PEND. Reset puts the FSM in IDLE.
- IDLE: `data_ready`=1. If data_valid=1:
  - latch data_in into the payload register;
  - clear the remainder to 4'b0000 and the bit counter to 0;
  - go to CALC.
- CALC: one payload bit per cycle, MSB first (data[11] first).
  - fb_bit = rem[3] ^ bit;
  - rem = {rem[2:0],1'b0} ^ (fb_bit ? 4'b0011 : 4'b0000).
  - After 12 bits (counter 0..11) go to PEND. No augmentation cycles are used; this form yields the remainder of payload·x^4 mod g.
- PEND: the result is held.
  - On fb: CRC_code <= {payload, rem}, code_valid <= 1, go to IDLE.
- fb while in IDLE or CALC: CRC_code <= IDLE_CODE, code_valid <= 0. A computation in progress continues unaffected and waits for the next fb.
- fb and handshake in the same cycle (IDLE): the payload is accepted; the boundary loads IDLE_CODE.
- Between boundaries, CRC_code and code_valid never change.
- data_in changes after the handshake have no effect.

## Timing
- Reset values: CRC_code=IDLE_CODE, code_valid=0, data_ready=1, remainder=0, counter=0.
- Handshake at cycle t gives CALC in cycles t+1..t+12 and PEND from t+13.
- The earliest output edge is the first fb at or after cycle t+13.
- One frame is 4096 cycles, so any payload accepted ≥13 cycles before fb is emitted at that fb.
- Throughput is one payload per frame. data_ready stays low from the handshake until the cycle after the output load.
- Reset asserted mid-operation returns the block to reset values immediately and discards the pending payload.
- phase and sign_cnt are synchronous to clk_sys; no resynchronisation.

## Structure
- Package `crc4fsk_pkg` holds:
  - DATA_W=12, CRC_W=4, CODE_W=16;
  - CRC_POLY=4'b0011;
  - the FSM state enum (IDLE, CALC, PEND);
  - a function or constant for the boundary values (SIGN_LAST=15, PHASE_LAST=255).
- Sub-module `crc4_step` is purely combinational: rem_in[3:0] and bit_in in, rem_out[3:0] out, implementing one LFSR step. The receive-side checker reuses it.

## Test plan
- Reset, no data: CRC_code=16'h0000 and code_valid=0 across 3 frames; data_ready=1.
- data_in=12'h001 accepted mid-frame: at the next fb, CRC_code=16'h0013 and code_valid=1 for exactly 4096 cycles; IDLE_CODE follows if nothing is queued.
- data_in=12'h800 gives 16'h8001. data_in=12'h002 gives 16'h0026. Sent back-to-back (each accepted right after the previous load), these occupy consecutive frames.
- Handshake 5 cycles before fb: that fb loads IDLE_CODE with code_valid=0; the payload appears at the following fb. Handshake exactly on the fb cycle behaves the same way.
- data_in toggled randomly after the handshake: the output still matches the latched value. data_valid held high in CALC/PEND: no second accept, data_ready=0.
- rst_n pulsed low during CALC and again during PEND: outputs return to reset values asynchronously and the payload is never emitted. After release, a new 12'h001 encodes correctly.

Source files
------------

// File: rtl/crc_frame_encoder_pkg.sv
// Shared constants, FSM state type and frame-boundary helper for the CRC-4/4FSK path.
// Used by the transmit encoder and by the receive-side checker.
package crc4fsk_pkg;

    localparam int DATA_W = 12;
    localparam int CRC_W  = 4;
    localparam int CODE_W = 16;

    localparam logic [CRC_W-1:0] CRC_POLY = 4'b0011;

    localparam logic [3:0] SIGN_LAST  = 4'd15;
    localparam logic [7:0] PHASE_LAST = 8'd255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        PEND = 2'd2
    } state_t;

    // True in the last clk_sys cycle of a 16-symbol frame.
    function automatic logic is_frame_boundary(input logic [3:0] sign_cnt, input logic [7:0] phase);
        return (sign_cnt == SIGN_LAST) && (phase == PHASE_LAST);
    endfunction

endpackage

// File: rtl/crc_frame_encoder_if.sv
// Payload handshake and code-word bus between the payload source, the encoder
// and the bit serializer.
interface crc_frame_encoder_if;
    import crc4fsk_pkg::*;

    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;
    logic [CODE_W-1:0] CRC_code;
    logic              code_valid;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready,
        input  CRC_code,
        input  code_valid
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready,
        output CRC_code,
        output code_valid
    );

endinterface

// File: rtl/crc_frame_encoder_crc4_step.sv
// One bit-serial LFSR step of CRC-4 (x^4+x+1), MSB-first, no augmentation.
// Shared between the transmit encoder and the receive checker.
module crc4_step
    import crc4fsk_pkg::*;
(
    input  logic [CRC_W-1:0] rem_in,
    input  logic             bit_in,
    output logic [CRC_W-1:0] rem_out
);

    logic fb_bit_s;

    assign fb_bit_s = rem_in[CRC_W-1] ^ bit_in;
    assign rem_out  = {rem_in[CRC_W-2:0], 1'b0} ^ (fb_bit_s ? CRC_POLY : 4'b0000);

endmodule

// File: rtl/crc_frame_encoder.sv
// Accepts a 12-bit payload, computes its CRC-4 bit-serially and publishes the
// 16-bit code word only on frame boundaries so it is stable for a whole frame.
module crc_frame_encoder
    import crc4fsk_pkg::*;
#(
    parameter logic [CODE_W-1:0] IDLE_CODE = 16'h0000
) (
    input  logic                  clk_sys,
    input  logic                  rst_n,
    input  logic [7:0]            phase,
    input  logic [3:0]            sign_cnt,
    crc_frame_encoder_if.slave    bus
);

    localparam logic [3:0] LAST_BIT = 4'd11;

    state_t             state_r;
    logic [DATA_W-1:0]  payload_r;
    logic [CRC_W-1:0]   rem_r;
    logic [3:0]         bit_cnt_r;
    logic [CODE_W-1:0]  code_r;
    logic               code_valid_r;
    logic               data_ready_r;

    logic               fb_s;
    logic               cur_bit_s;
    logic [CRC_W-1:0]   step_rem_s;

    assign fb_s      = is_frame_boundary(sign_cnt, phase);
    assign cur_bit_s = payload_r[LAST_BIT - bit_cnt_r];

    crc4_step u_step (
        .rem_in  (rem_r),
        .bit_in  (cur_bit_s),
        .rem_out (step_rem_s)
    );

    // Encoder FSM plus frame-aligned output register; the computation runs
    // independently of the boundary, which only decides what word is published.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            payload_r    <= 12'h000;
            rem_r        <= 4'b0000;
            bit_cnt_r    <= 4'd0;
            code_r       <= IDLE_CODE;
            code_valid_r <= 1'b0;
            data_ready_r <= 1'b1;
        end else begin
            if (fb_s) begin
                if (state_r == PEND) begin
                    code_r       <= {payload_r, rem_r};
                    code_valid_r <= 1'b1;
                end else begin
                    code_r       <= IDLE_CODE;
                    code_valid_r <= 1'b0;
                end
            end else begin
                code_r       <= code_r;
                code_valid_r <= code_valid_r;
            end

            case (state_r)
                IDLE: begin
                    if (bus.data_valid) begin
                        payload_r    <= bus.data_in;
                        rem_r        <= 4'b0000;
                        bit_cnt_r    <= 4'd0;
                        data_ready_r <= 1'b0;
                        state_r      <= CALC;
                    end else begin
                        data_ready_r <= 1'b1;
                    end
                end
                CALC: begin
                    rem_r     <= step_rem_s;
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                    if (bit_cnt_r == LAST_BIT) begin
                        state_r <= PEND;
                    end else begin
                        state_r <= CALC;
                    end
                end
                PEND: begin
                    if (fb_s) begin
                        data_ready_r <= 1'b1;
                        state_r      <= IDLE;
                    end else begin
                        state_r <= PEND;
                    end
                end
                default: begin
                    data_ready_r <= 1'b1;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign bus.CRC_code   = code_r;
    assign bus.code_valid = code_valid_r;
    assign bus.data_ready = data_ready_r;

endmodule

// File: tb/tb_crc_frame_encoder.sv
// Directed bench for crc_frame_encoder: a free-running 4096-cycle frame
// counter stands in for the timing block; expected words are hand-computed.
module tb_crc_frame_encoder;
    import crc4fsk_pkg::*;

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b0;
    logic [11:0] cnt     = 12'd0;
    logic [7:0]  phase;
    logic [3:0]  sign_cnt;
    int          checks   = 0;
    int          failures = 0;
    int          bad;

    crc_frame_encoder_if bus ();

    crc_frame_encoder #(.IDLE_CODE(16'h0000)) dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .phase    (phase),
        .sign_cnt (sign_cnt),
        .bus      (bus.slave)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cnt <= cnt + 12'd1;

    assign phase    = cnt[7:0];
    assign sign_cnt = cnt[11:8];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Advance (on negedges) until the counter the DUT sees at the next posedge equals target.
    task automatic goto_cnt(input logic [11:0] target);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (cnt == target) begin
                found = 1'b1;
                break;
            end
            @(negedge clk_sys);
        end
        if (!found) chk("goto_timeout", 16'd0, 16'd1);
    endtask

    task automatic offer(input logic [11:0] d);
        bus.data_in    = d;
        bus.data_valid = 1'b1;
        @(negedge clk_sys);
        bus.data_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [15:0] code, input logic vld, input logic rdy);
        chk({tag, "_code"},  bus.CRC_code, code);
        chk({tag, "_valid"}, {15'd0, bus.code_valid}, {15'd0, vld});
        chk({tag, "_ready"}, {15'd0, bus.data_ready}, {15'd0, rdy});
    endtask

    initial begin
        bus.data_in    = 12'h000;
        bus.data_valid = 1'b0;
        repeat (3) @(negedge clk_sys);
        check_out("reset", 16'h0000, 1'b0, 1'b1);
        rst_n = 1'b1;

        // Idle frames publish IDLE_CODE.
        for (int f = 0; f < 3; f++) begin
            goto_cnt(12'd4095);
            @(negedge clk_sys);
            check_out("idle_frame", 16'h0000, 1'b0, 1'b1);
        end

        // 12'h001 accepted mid-frame.
        goto_cnt(12'd2000);
        offer(12'h001);
        chk("ready_low_calc", {15'd0, bus.data_ready}, 16'd0);
        goto_cnt(12'd4095);
        chk("hold_before_fb", bus.CRC_code, 16'h0000);
        @(negedge clk_sys);
        check_out("p001", 16'h0013, 1'b1, 1'b1);
        bad = 0;
        for (int i = 1; i < 4096; i++) begin
            @(negedge clk_sys);
            if (bus.CRC_code !== 16'h0013 || bus.code_valid !== 1'b1) bad++;
        end
        chk("p001_stable_4096", bad[15:0], 16'd0);
        @(negedge clk_sys);
        check_out("after_p001", 16'h0000, 1'b0, 1'b1);

        // Back-to-back 12'h800 then 12'h002; data_in scrambled and valid held after accept.
        goto_cnt(12'd100);
        offer(12'h800);
        goto_cnt(12'd4095);
        @(negedge clk_sys);
        check_out("p800", 16'h8001, 1'b1, 1'b1);
        bus.data_in    = 12'h002;
        bus.data_valid = 1'b1;
        @(negedge clk_sys);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            bus.data_in = 12'($urandom);
            if (bus.data_ready !== 1'b0) bad++;
            @(negedge clk_sys);
        end
        bus.data_valid = 1'b0;
        chk("no_second_accept", bad[15:0], 16'd0);
        chk("p800_still_held", bus.CRC_code, 16'h8001);
        goto_cnt(12'd4095);
        @(negedge clk_sys);
        check_out("p002", 16'h0026, 1'b1, 1'b1);

        // Handshake 5 cycles before the boundary misses it.
        goto_cnt(12'd4090);
        offer(12'h800);
        goto_cnt(12'd4095);
        @(negedge clk_sys);
        check_out("late_hs", 16'h0000, 1'b0, 1'b0);
        goto_cnt(12'd4095);
        @(negedge clk_sys);
        check_out("late_hs_next", 16'h8001, 1'b1, 1'b1);

        // Handshake on the boundary cycle itself.
        goto_cnt(12'd4095);
        offer(12'h002);
        check_out("fb_hs", 16'h0000, 1'b0, 1'b0);
        goto_cnt(12'd4095);
        @(negedge clk_sys);
        check_out("fb_hs_next", 16'h0026, 1'b1, 1'b1);

        // Reset during CALC clears outputs asynchronously.
        goto_cnt(12'd1000);
        offer(12'h001);
        #2 rst_n = 1'b0;
        #1 check_out("rst_calc", 16'h0000, 1'b0, 1'b1);
        @(negedge clk_sys);
        rst_n = 1'b1;

        // Reset during PEND.
        offer(12'h800);
        repeat (15) @(negedge clk_sys);
        chk("pend_ready_low", {15'd0, bus.data_ready}, 16'd0);
        #2 rst_n = 1'b0;
        #1 check_out("rst_pend", 16'h0000, 1'b0, 1'b1);
        @(negedge clk_sys);
        rst_n = 1'b1;
        goto_cnt(12'd4095);
        @(negedge clk_sys);
        check_out("discarded", 16'h0000, 1'b0, 1'b1);

        // Fresh payload after reset.
        goto_cnt(12'd500);
        offer(12'h001);
        goto_cnt(12'd4095);
        @(negedge clk_sys);
        check_out("post_rst_p001", 16'h0013, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
